// File: rtl/mem_array_arbiter_if.sv
// Requester-side bus of mem_array_arbiter: two request/operand channels,
// their acknowledges, and the shared read result with its error flag.
interface mem_array_arbiter_if #(
  parameter int ADDR_W = 4
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [7:0]        wdata0;
  logic              ack0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [7:0]        wdata1;
  logic              ack1;
  logic [7:0]        rdata;
  logic              err;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, ack1, rdata, err
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, ack1, rdata, err
  );
endinterface

// File: rtl/mem_array_arbiter.sv
// Round-robin two-requester controller for a byte-wide word array: latches the
// winning request, drives a one-hot word select for a fixed window, then acks.
module mem_array_arbiter #(
  parameter int WORDS      = 16,
  parameter int ADDR_W     = 4,
  parameter int ACCESS_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_array_arbiter_if.slave  bus,
  output logic                busy,
  output logic [WORDS-1:0]    mem_sel,
  output logic                mem_rw,
  output logic [7:0]          mem_din,
  input  logic [7:0]          mem_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYC - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(WORDS));
  endfunction

  function automatic logic [WORDS-1:0] decode_sel(input logic [ADDR_W-1:0] a);
    logic [WORDS-1:0] s;
    for (int i = 0; i < WORDS; i++) begin
      s[i] = (32'(a) == 32'(i));
    end
    return s;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic              last_grant_r;
  logic              owner_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        wdata_r;
  logic [3:0]        cnt_r;

  logic              gnt_valid_s;
  logic              gnt_s;
  logic              op_we_s;
  logic [ADDR_W-1:0] op_addr_s;
  logic [7:0]        op_wdata_s;
  logic              op_ok_s;

  logic [WORDS-1:0]  sel_nxt_s;
  logic              rw_nxt_s;
  logic [7:0]        din_nxt_s;
  logic              ack0_nxt_s;
  logic              ack1_nxt_s;
  logic              err_nxt_s;
  logic [7:0]        rdata_nxt_s;
  logic              busy_nxt_s;

  logic [WORDS-1:0]  sel_r;
  logic              rw_r;
  logic [7:0]        din_r;
  logic              ack0_r;
  logic              ack1_r;
  logic              err_r;
  logic [7:0]        rdata_r;
  logic              busy_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and round-robin grant decision.
  always_comb begin
    state_nxt_s = state_r;
    gnt_valid_s = 1'b0;
    gnt_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          gnt_valid_s = 1'b1;
          gnt_s       = ~last_grant_r;
        end else if (bus.req0) begin
          gnt_valid_s = 1'b1;
          gnt_s       = 1'b0;
        end else if (bus.req1) begin
          gnt_valid_s = 1'b1;
          gnt_s       = 1'b1;
        end else begin
          gnt_valid_s = 1'b0;
          gnt_s       = 1'b0;
        end
        if (gnt_valid_s) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operands for the coming cycle: the winner's inputs on a grant, else the latched copy.
  always_comb begin
    op_we_s    = we_r;
    op_addr_s  = addr_r;
    op_wdata_s = wdata_r;
    if (state_r == IDLE) begin
      if (gnt_s) begin
        op_we_s    = bus.we1;
        op_addr_s  = bus.addr1;
        op_wdata_s = bus.wdata1;
      end else begin
        op_we_s    = bus.we0;
        op_addr_s  = bus.addr0;
        op_wdata_s = bus.wdata0;
      end
    end else begin
      op_we_s    = we_r;
      op_addr_s  = addr_r;
      op_wdata_s = wdata_r;
    end
    op_ok_s = in_range(op_addr_s);
  end

  // Request latch, access window counter and grant history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= 8'h00;
      cnt_r        <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            last_grant_r <= gnt_s;
            owner_r      <= gnt_s;
            we_r         <= op_we_s;
            addr_r       <= op_addr_s;
            wdata_r      <= op_wdata_s;
            cnt_r        <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output values for the next state; decoded ahead so the array pins come straight from flops.
  always_comb begin
    sel_nxt_s   = '0;
    rw_nxt_s    = 1'b1;
    din_nxt_s   = 8'h00;
    ack0_nxt_s  = 1'b0;
    ack1_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    rdata_nxt_s = rdata_r;
    busy_nxt_s  = (state_nxt_s != IDLE);
    case (state_nxt_s)
      ACCESS: begin
        if (op_ok_s) begin
          sel_nxt_s = decode_sel(op_addr_s);
          rw_nxt_s  = ~op_we_s;
          din_nxt_s = op_we_s ? op_wdata_s : 8'h00;
        end else begin
          sel_nxt_s = '0;
          rw_nxt_s  = 1'b1;
          din_nxt_s = 8'h00;
        end
      end
      DONE: begin
        ack0_nxt_s = ~owner_r;
        ack1_nxt_s = owner_r;
        err_nxt_s  = ~in_range(addr_r);
        // Entering DONE is the final ACCESS edge: the selected word is still driving mem_dout.
        if (!we_r) begin
          rdata_nxt_s = in_range(addr_r) ? mem_dout : 8'h00;
        end else begin
          rdata_nxt_s = rdata_r;
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r   <= '0;
      rw_r    <= 1'b1;
      din_r   <= 8'h00;
      ack0_r  <= 1'b0;
      ack1_r  <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 8'h00;
      busy_r  <= 1'b0;
    end else begin
      sel_r   <= sel_nxt_s;
      rw_r    <= rw_nxt_s;
      din_r   <= din_nxt_s;
      ack0_r  <= ack0_nxt_s;
      ack1_r  <= ack1_nxt_s;
      err_r   <= err_nxt_s;
      rdata_r <= rdata_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign mem_sel   = sel_r;
  assign mem_rw    = rw_r;
  assign mem_din   = din_r;
  assign busy      = busy_r;
  assign bus.ack0  = ack0_r;
  assign bus.ack1  = ack1_r;
  assign bus.err   = err_r;
  assign bus.rdata = rdata_r;

endmodule

// File: doc/mem_array_arbiter.md
Name: mem_array_arbiter

Overview:
- Two-requester controller for a memory array built from byte-wide word units.
- Each word unit has 8 bitcells sharing one select line and one read/write line.
- The block arbitrates between requesters 0 and 1 (round-robin), latches the winning request, and decodes the address into a one-hot word select.
- It drives the array's shared rw and write-data lines for a fixed access window, captures read data, and returns a one-cycle acknowledge.

Parameters:
- WORDS, 16, number of byte words in the array.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= WORDS.
- ACCESS_CYC, 2, cycles the word select is held asserted (range 1..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 access request; level, held until ack0.
- we0  input  1  requester 0 operation: 1 = write, 0 = read.
- addr0  input  ADDR_W  requester 0 word address.
- wdata0  input  8  requester 0 write byte.
- ack0  output  1  one-cycle completion pulse to requester 0.
- req1, we1, addr1, wdata1, ack1: same as the requester 0 ports, for requester 1.
- rdata  output  8  read result, shared by both requesters; valid in the ack cycle, held until the next read completes.
- err  output  1  asserted together with ack when the address is >= WORDS.
- busy  output  1  high in any state other than IDLE.
- mem_sel  output  WORDS  one-hot word select to the array; all zero when idle.
- mem_rw  output  1  array rw line: 1 = read, 0 = write.
- mem_din  output  8  byte driven to the selected word's bitcell inputs.
- mem_dout  input  8  byte returned from the selected word's bitcell outputs.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, all outputs 0 except mem_rw = 1 (read, so no cell is written).
  - last_grant = 1, so requester 0 wins the first contention.
  - Reset mid-operation aborts the access: sel drops immediately, no ack is issued, rdata is cleared.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_grant, then update last_grant.
  - On grant, latch we, addr and wdata into internal registers and go to ACCESS.
  - Request inputs are not sampled again until the next return to IDLE.
- ACCESS:
  - Lasts exactly ACCESS_CYC cycles; a down-counter is loaded with ACCESS_CYC-1 on entry.
  - mem_sel[addr] = 1; all other select bits are 0.
  - mem_rw = ~we_latched.
  - mem_din = wdata_latched for writes, 0 for reads.
  - On a read, rdata captures mem_dout on the final ACCESS edge.
  - Then go to DONE.
- Out-of-range address (addr >= WORDS):
  - ACCESS still runs its full length, with mem_sel all zero and mem_rw = 1.
  - rdata is loaded with 0x00, and err is pulsed in DONE.
- DONE (1 cycle):
  - mem_sel = 0 and mem_rw = 1.
  - Pulse ack of the granted requester, with err as computed; return to IDLE.
- Latency: a req sampled high in IDLE at edge N gives mem_sel high for cycles N+1..N+ACCESS_CYC and ack in cycle N+ACCESS_CYC+1.
- Minimum spacing between grants: ACCESS_CYC+2 cycles.
- Requester rules:
  - Deassert req in the cycle after ack.
  - A req still high in the IDLE cycle after ack counts as a new request.
  - The losing requester waits; its req and operands must stay stable.
- Writes leave rdata unchanged.
- busy = (state != IDLE).
- Only one mem_sel bit is ever high. mem_sel and mem_rw change only on clock edges.

Test Plan:
- Single write then read, ACCESS_CYC=2:
  - req0, we0=1, addr0=5, wdata0=0xA5 -> mem_sel=0x0020 and mem_rw=0 for 2 cycles, then ack0; err=0.
  - Then a read of addr 5, with the array model returning 0xA5 -> rdata=0xA5 in the ack0 cycle.
- Simultaneous requests after reset:
  - req0 read addr 1 and req1 read addr 2 in the same cycle -> requester 0 served first, ack0 at cycle +3.
  - Requester 1 is then granted the cycle after return to IDLE, ack1 at cycle +7.
  - A third contention goes to requester 0 again (alternation holds).
- Continuous contention: both reqs held high for 20 accesses -> acks alternate 0,1,0,1,…, with exactly ACCESS_CYC+2 cycles between acks.
- Out of range, WORDS=12: req1 read addr 14 -> mem_sel stays 0 throughout, ack1 and err both 1, rdata=0x00.
- Reset mid-access: assert rst_n=0 during the 2nd ACCESS cycle -> mem_sel=0, mem_rw=1, busy=0 immediately; no ack after release; the next contention grants requester 0.
- Write leaves rdata: read addr 3 returning 0x3C, then write addr 3 with 0xFF -> rdata remains 0x3C after the write ack.
